// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/result handshake bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start_valid, a, b, result_ready,
    input  start_ready, result_valid, diff, borrow_out, overflow, zero
  );

  modport slave (
    input  start_valid, a, b, result_ready,
    output start_ready, result_valid, diff, borrow_out, overflow, zero
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor, LSB first, one
//               full-subtractor cell per clock, valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  serial_subtractor_if.slave bus
);

  localparam int            CW           = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last_count = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic             r_nonzero;
  logic             r_borrow_out;
  logic             r_overflow;
  logic             r_zero;

  logic             w_start_ready;
  logic             w_result_valid;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bout;

  // Full-subtractor cell on the current LSBs
  assign w_d    = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
  assign w_bout = (~r_a_sh[0] & r_b_sh[0]) | (~r_a_sh[0] & r_borrow) | (r_b_sh[0] & r_borrow);

  assign w_accept = w_start_ready & bus.start_valid;
  assign w_last   = (r_count == c_last_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_start_ready  = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start_ready = 1'b1;
        if (bus.start_valid) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_result_valid = 1'b1;
        if (bus.result_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_diff       <= '0;
      r_count      <= '0;
      r_borrow     <= 1'b0;
      r_nonzero    <= 1'b0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a_sh       <= bus.a;
            r_b_sh       <= bus.b;
            r_diff       <= '0;
            r_count      <= '0;
            r_borrow     <= 1'b0;
            r_nonzero    <= 1'b0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_diff    <= {w_d, r_diff[WIDTH-1:1]};
          r_borrow  <= w_bout;
          r_nonzero <= r_nonzero | w_d;
          r_count   <= r_count + 1'b1;
          // On the last step the LSBs of the shifters are the operand sign bits
          if (w_last) begin
            r_borrow_out <= w_bout;
            r_overflow   <= (r_a_sh[0] != r_b_sh[0]) && (w_d != r_a_sh[0]);
            r_zero       <= ~(r_nonzero | w_d);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready  = w_start_ready;
  assign bus.result_valid = w_result_valid;
  assign bus.diff         = r_diff;
  assign bus.borrow_out   = r_borrow_out;
  assign bus.overflow     = r_overflow;
  assign bus.zero         = r_zero;

endmodule
`default_nettype wire
